// File: rtl/shift_sub_divider_pkg.sv
// Shared definitions for the shift/subtract divider: FSM state encodings
// (common with the shift-add multiplier controller) and a log2 helper.
// Optional feature macro used across this slice: DIV_ZERO_DETECT_EN.
package shift_sub_divider_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Ceiling log2, usable in constant expressions for sizing counters.
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_sub_divider_if.sv
// Request/result bundle of the shift/subtract divider.
// Optional macro: DIV_ZERO_DETECT_EN adds the div_by_zero result flag.
//
// Handshake: the master raises start with dividend/divisor valid; the
// request is taken on any rising clk edge where busy is low (IDLE or DONE).
// While busy is high start is ignored. done is a one-cycle pulse marking
// quotient/remainder (and div_by_zero) valid; the results then hold until
// the next accepted start.
interface shift_sub_divider_if #(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

`ifdef DIV_ZERO_DETECT_EN
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder
  );
`endif

endinterface

// File: rtl/shift_sub_divider_counter.sv
// Iteration counter for the divider: cleared when an operation is accepted,
// incremented every CALC cycle, flags the final iteration.
module shift_sub_divider_counter
  import shift_sub_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);

  // One extra bit so the count can reach WIDTH without wrapping.
  localparam int CW = log2_ceil(WIDTH) + 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// FSM IDLE -> CALC (WIDTH cycles) -> DONE (1 cycle) with the R/Q/divisor
// datapath. Optional macro: DIV_ZERO_DETECT_EN (early exit on divisor 0
// plus a div_by_zero flag).
module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_sub_divider_if.slave    bus,
  output state_t                dbg_state
);

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
`ifdef DIV_ZERO_DETECT_EN
  logic             dbz_q, dbz_d;
`endif

  logic             start_ok;
  logic             last;

  logic [2*WIDTH:0] rq_shift;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;

  assign start_ok = bus.start && (state_q != ST_CALC);

  shift_sub_divider_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .inc   (state_q == ST_CALC),
    .last  (last)
  );

  // One restoring step: shift {R,Q} left, try subtracting the divisor, keep
  // the difference and set the new quotient bit only if it did not go negative.
  always_comb begin
    rq_shift = {r_q, q_q} << 1;
    r_shift  = rq_shift[2*WIDTH:WIDTH];
    trial    = r_shift - {1'b0, dvs_q};
    r_step   = trial[WIDTH] ? r_shift : trial;
    q_step   = rq_shift[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      ST_CALC: begin
        r_d = r_step;
        q_d = q_step;
        if (last) begin
          state_d = ST_DONE;
          quot_d  = q_step;
          rem_d   = r_step[WIDTH-1:0];
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        if (bus.start) begin
          state_d = ST_CALC;
          r_d     = '0;
          q_d     = bus.dividend;
          dvs_d   = bus.divisor;
`ifdef DIV_ZERO_DETECT_EN
          dbz_d   = 1'b0;
          if (bus.divisor == '0) begin
            // Result is known up front; skip the iterations.
            state_d = ST_DONE;
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign bus.busy      = (state_q == ST_CALC);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
`ifdef DIV_ZERO_DETECT_EN
  assign bus.div_by_zero = dbz_q;
`endif
  assign dbg_state     = state_q;

endmodule
